// File: rtl/camera_stream_gen.sv
// OV7670-style pixel-stream source: pclk/vsync/href/data from an internal pattern generator.
// Everything except pclk advances only on the clk_in cycle where pclk falls.
module camera_stream_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2,
  parameter int CLK_DIV     = 2,
  parameter int BAR_W       = 40
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] color_in,
  input  logic [8:0]  target_x,
  input  logic [8:0]  target_y,
  input  logic [7:0]  target_r,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  data_out,
  output logic        frame_done_out,
  output logic        busy_out
);

  localparam int L   = 2*H_ACTIVE + H_BLANK;
  localparam int HW  = $clog2(L);
  localparam int VM1 = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int VM2 = (VM1 > V_BACK) ? VM1 : V_BACK;
  localparam int VM  = (VM2 > V_FRONT) ? VM2 : V_FRONT;
  localparam int LW  = $clog2(VM + 1);
  localparam int DW  = $clog2(CLK_DIV + 1);
  localparam int BW  = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t          r_state, w_state_nx;
  logic [DW-1:0]   r_div;
  logic            r_pclk;
  logic [HW-1:0]   r_h, w_h_nx;
  logic [LW-1:0]   r_line, w_line_nx;
  logic [2:0]      r_bar, w_bar_nx;
  logic [BW-1:0]   r_barcnt, w_barcnt_nx;
  logic [15:0]     r_rowbase, w_row_nx;
  logic [1:0]      r_pat;
  logic [11:0]     r_col;
  logic [8:0]      r_tx, r_ty;
  logic [7:0]      r_tr;
  logic            r_vs, r_href, r_done, r_busy;
  logic [7:0]      r_data;

  logic            w_fall, w_snap, w_done, w_act, w_in_box;
  int              w_nlines;
  logic [9:0]      w_x, w_y, w_dx, w_dy, w_ax, w_ay;
  logic [15:0]     w_exp, w_barc, w_pix;
  logic [7:0]      w_data_nx;

  assign w_fall = r_pclk && (int'(r_div) == CLK_DIV - 1);

  always_comb begin
    w_state_nx = r_state;
    w_h_nx     = r_h;
    w_line_nx  = r_line;
    case (r_state)
      S_VSYNC:  w_nlines = VSYNC_LINES;
      S_VBACK:  w_nlines = V_BACK;
      S_ACTIVE: w_nlines = V_ACTIVE;
      default:  w_nlines = V_FRONT;
    endcase
    if (r_state == S_IDLE) begin
      if (enable_in) begin
        w_state_nx = S_VSYNC;
        w_h_nx     = '0;
        w_line_nx  = '0;
      end
    end else if (int'(r_h) == L - 1) begin
      w_h_nx = '0;
      if (int'(r_line) == w_nlines - 1) begin
        w_line_nx = '0;
        case (r_state)
          S_VSYNC:  w_state_nx = S_VBACK;
          S_VBACK:  w_state_nx = S_ACTIVE;
          S_ACTIVE: w_state_nx = S_VFRONT;
          default:  w_state_nx = enable_in ? S_VSYNC : S_IDLE;
        endcase
      end else begin
        w_line_nx = r_line + 1'b1;
      end
    end else begin
      w_h_nx = r_h + 1'b1;
    end
  end

  // Bar index tracks the pixel about to be output; it restarts at each line start.
  always_comb begin
    w_bar_nx    = r_bar;
    w_barcnt_nx = r_barcnt;
    if (w_h_nx == '0) begin
      w_bar_nx    = '0;
      w_barcnt_nx = '0;
    end else if (!w_h_nx[0]) begin
      if (int'(r_barcnt) == BAR_W - 1) begin
        w_barcnt_nx = '0;
        if (r_bar != 3'd7) w_bar_nx = r_bar + 3'd1;
      end else begin
        w_barcnt_nx = r_barcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_row_nx = r_rowbase;
    if (w_state_nx == S_ACTIVE && w_h_nx == '0)
      w_row_nx = (r_state == S_ACTIVE) ? r_rowbase + 16'(H_ACTIVE) : 16'h0000;
  end

  assign w_x  = 10'(w_h_nx >> 1);
  assign w_y  = 10'(w_line_nx);
  assign w_dx = w_x - {1'b0, r_tx};
  assign w_dy = w_y - {1'b0, r_ty};
  assign w_ax = w_dx[9] ? (10'd0 - w_dx) : w_dx;
  assign w_ay = w_dy[9] ? (10'd0 - w_dy) : w_dy;
  assign w_in_box = (w_ax <= {2'b00, r_tr}) && (w_ay <= {2'b00, r_tr});
  assign w_exp = {r_col[11:8], r_col[11], r_col[7:4], r_col[7:6], r_col[3:0], r_col[3]};

  always_comb begin
    case (w_bar_nx)
      3'd0:    w_barc = 16'hFFFF;
      3'd1:    w_barc = 16'hFFE0;
      3'd2:    w_barc = 16'h07FF;
      3'd3:    w_barc = 16'h07E0;
      3'd4:    w_barc = 16'hF81F;
      3'd5:    w_barc = 16'hF800;
      3'd6:    w_barc = 16'h001F;
      default: w_barc = 16'h0000;
    endcase
    case (r_pat)
      2'd0:    w_pix = w_exp;
      2'd1:    w_pix = w_barc;
      2'd2:    w_pix = w_in_box ? w_exp : 16'h0000;
      default: w_pix = w_row_nx + 16'(w_x);
    endcase
  end

  assign w_act     = (w_state_nx == S_ACTIVE) && (int'(w_h_nx) < 2*H_ACTIVE);
  assign w_data_nx = !w_act ? 8'h00 : (w_h_nx[0] ? w_pix[7:0] : w_pix[15:8]);
  assign w_snap    = (w_state_nx == S_VSYNC) && (r_state != S_VSYNC);
  assign w_done    = (r_state == S_ACTIVE) && (int'(r_line) == V_ACTIVE - 1) &&
                     (int'(r_h) == 2*H_ACTIVE - 1);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_pclk    <= 1'b0;
      r_h       <= '0;
      r_line    <= '0;
      r_bar     <= '0;
      r_barcnt  <= '0;
      r_rowbase <= '0;
      r_pat     <= '0;
      r_col     <= '0;
      r_tx      <= '0;
      r_ty      <= '0;
      r_tr      <= '0;
      r_vs      <= 1'b0;
      r_href    <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (int'(r_div) == CLK_DIV - 1) begin
        r_div  <= '0;
        r_pclk <= ~r_pclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fall) begin
        r_state   <= w_state_nx;
        r_h       <= w_h_nx;
        r_line    <= w_line_nx;
        r_bar     <= w_bar_nx;
        r_barcnt  <= w_barcnt_nx;
        r_rowbase <= w_row_nx;
        r_vs      <= (w_state_nx == S_VSYNC);
        r_href    <= w_act;
        r_data    <= w_data_nx;
        r_busy    <= (w_state_nx != S_IDLE);
        r_done    <= w_done;
        if (w_snap) begin
          r_pat <= pattern_sel;
          r_col <= color_in;
          r_tx  <= target_x;
          r_ty  <= target_y;
          r_tr  <= target_r;
        end
      end
    end
  end

  assign pclk_out       = r_pclk;
  assign vsync_out      = r_vs;
  assign href_out       = r_href;
  assign data_out       = r_data;
  assign frame_done_out = r_done;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_camera_stream_gen.sv
// Scoreboard bench: a small-geometry instance for frame/pattern/enable/reset behaviour,
// plus a default-geometry instance checked on the first color-bar line.
module tb_camera_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_b_n, en, en_b;
  logic [1:0]  pat;
  logic [11:0] col;
  logic [8:0]  tx, ty;
  logic [7:0]  tr;
  logic        s_pclk, s_vs, s_href, s_done, s_busy;
  logic [7:0]  s_data;
  logic        b_pclk, b_vs, b_href, b_done, b_busy;
  logic [7:0]  b_data;

  camera_stream_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .CLK_DIV(1), .BAR_W(1)
  ) u_small (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en), .pattern_sel(pat), .color_in(col),
    .target_x(tx), .target_y(ty), .target_r(tr),
    .pclk_out(s_pclk), .vsync_out(s_vs), .href_out(s_href), .data_out(s_data),
    .frame_done_out(s_done), .busy_out(s_busy)
  );

  camera_stream_gen u_bars (
    .clk_in(clk), .rst_in(rst_b_n), .enable_in(en_b), .pattern_sel(2'd1), .color_in(12'h000),
    .target_x(9'd0), .target_y(9'd0), .target_r(8'd0),
    .pclk_out(b_pclk), .vsync_out(b_vs), .href_out(b_href), .data_out(b_data),
    .frame_done_out(b_done), .busy_out(b_busy)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0] qs[$];
  logic [7:0] qb[$];
  logic [15:0] tab [0:5][0:11];
  logic [15:0] bars4 [0:3];
  logic [15:0] bar8 [0:7];

  int pcnt = 0, bursts = 0, dones = 0, g_done = 0, vs_cnt = 0;
  int brk_cnt = 0;
  int bi = 0;
  logic bdone = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int f);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] v;
      v = tab[f][i];
      qs.push_back(v[15:8]);
      qs.push_back(v[7:0]);
    end
  endtask

  task automatic wait_vs(input int budget);
    int start = vs_cnt;
    int n = 0;
    while (vs_cnt == start && n < budget) begin tick(); n++; end
    chk("vsync_seen", int'(vs_cnt != start), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (s_busy && n < budget) begin tick(); n++; end
    chk("busy_fall", int'(s_busy), 0);
    chk("frame_pclks_to_idle", pcnt, 60);
    chk("frame_bursts", bursts, 3);
    chk("frame_done_pulses", dones, 1);
    brk_cnt++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pclk"}, int'(s_pclk), 0);
    chk({tag, "_vsync"}, int'(s_vs), 0);
    chk({tag, "_href"}, int'(s_href), 0);
    chk({tag, "_data"}, int'(s_data), 0);
    chk({tag, "_done"}, int'(s_done), 0);
    chk({tag, "_busy"}, int'(s_busy), 0);
  endtask

  // small-instance monitor
  initial begin
    logic pq = 1'b0, hq = 1'b0, vq = 1'b0, have_prev = 1'b0;
    int brk_seen = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (s_pclk && !pq) begin
        pcnt++;
        if (s_href) begin
          if (qs.size() == 0) chk("s_byte_unexpected", 1, 0);
          else begin e = qs.pop_front(); chk("s_byte", int'(s_data), int'(e)); end
        end
      end
      if (s_href && !hq) bursts++;
      if (s_done) begin dones++; g_done++; end
      if (s_vs && !vq) begin
        if (have_prev && brk_seen == brk_cnt) begin
          chk("frame_period_pclks", pcnt, 60);
          chk("frame_bursts", bursts, 3);
          chk("frame_done_pulses", dones, 1);
        end
        brk_seen  = brk_cnt;
        have_prev = 1'b1;
        pcnt = 0; bursts = 0; dones = 0;
        vs_cnt++;
      end
      pq = s_pclk; hq = s_href; vq = s_vs;
    end
  end

  // default-geometry monitor: first active line, bytes at x = 0,40,...,280
  initial begin
    logic pq = 1'b0, hq = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (b_pclk && !pq && b_href && !bdone) begin
        if (bi % 80 < 2) begin
          if (qb.size() == 0) chk("bar_byte_unexpected", 1, 0);
          else begin e = qb.pop_front(); chk("bar_byte", int'(b_data), int'(e)); end
        end
        bi++;
      end
      if (!b_href && hq) bdone = 1'b1;
      pq = b_pclk; hq = b_href;
    end
  end

  initial begin
    int gd;
    int vs0;
    int n;
    bars4 = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0};
    bar8  = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      tab[0][i] = 16'hF800;
      tab[1][i] = 16'h07E0;
      tab[2][i] = (i == 5) ? 16'h07E0 : 16'h0000;
      tab[3][i] = (i == 0 || i == 1 || i == 4 || i == 5) ? 16'hFFFF : 16'h0000;
      tab[4][i] = 16'(i);
      tab[5][i] = bars4[i % 4];
    end
    for (int i = 0; i < 8; i++) begin
      qb.push_back(bar8[i][15:8]);
      qb.push_back(bar8[i][7:0]);
    end

    rst_n = 1'b0; rst_b_n = 1'b0; en = 1'b0; en_b = 1'b0;
    pat = 2'd0; col = 12'hF00; tx = 9'd0; ty = 9'd0; tr = 8'd0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1; rst_b_n = 1'b1; en_b = 1'b1;
    tick();
    chk("idle_no_busy", int'(s_busy), 0);
    en = 1'b1;

    wait_vs(100); push_frame(0); col = 12'h0F0;
    wait_vs(200); push_frame(1); pat = 2'd2; tx = 9'd1; ty = 9'd1; tr = 8'd0;
    wait_vs(200); push_frame(2); tx = 9'd0; ty = 9'd0; tr = 8'd1; col = 12'hFFF;
    wait_vs(200); push_frame(3); pat = 2'd3;
    wait_vs(200); push_frame(4); pat = 2'd1;
    wait_vs(200); push_frame(5);
    repeat (50) tick();
    en = 1'b0;
    chk("busy_mid_frame", int'(s_busy), 1);
    wait_idle(200);
    vs0 = vs_cnt;
    repeat (100) tick();
    chk("no_vsync_after_disable", vs_cnt, vs0);
    chk("idle_busy_low", int'(s_busy), 0);
    chk("scoreboard_drained", qs.size(), 0);

    pat = 2'd0; col = 12'hF00; en = 1'b1;
    wait_vs(100); push_frame(0);
    repeat (50) tick();
    chk("pre_reset_href", int'(s_href), 1);
    gd = g_done;
    rst_n = 1'b0;
    tick();
    qs.delete();
    brk_cnt++;
    chk_zero("midreset");
    tick();
    chk("midreset_no_done", g_done, gd);
    rst_n = 1'b1;
    push_frame(0);
    wait_vs(100);
    repeat (60) tick();
    en = 1'b0;
    wait_idle(200);
    chk("scoreboard_drained_after_reset", qs.size(), 0);

    n = 0;
    while (!bdone && n < 20000) begin tick(); n++; end
    chk("bar_line_seen", int'(bdone), 1);
    chk("bar_line_bytes", bi, 640);
    chk("bar_queue_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
